card_digit_scheduler: RTL and testbench

//  Shares one combinational 7-seg glyph renderer (80x140 px glyph, 4-bit digit in,

---
 rtl/card_digit_scheduler_pkg.sv | 51 +++++
 rtl/card_digit_scheduler_slot_locate.sv | 95 +++++++++
 rtl/card_digit_scheduler.sv | 161 ++++++++++++++++
 tb/tb_card_digit_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_digit_scheduler_pkg.sv
// Shared geometry, widths and digit helpers for the card digit scheduler.
package card_digit_scheduler_pkg;

   localparam int unsigned COORD_W   = 10;
   localparam int unsigned VALUE_W   = 4;
   localparam int unsigned SLOT_W    = 2;
   localparam int unsigned NUM_SLOTS = 4;

   localparam int unsigned DEF_GRID_X0    = 80;
   localparam int unsigned DEF_GRID_Y0    = 60;
   localparam int unsigned DEF_COL_PITCH  = 300;
   localparam int unsigned DEF_ROW_PITCH  = 200;
   localparam int unsigned DEF_DIGIT_W    = 80;
   localparam int unsigned DEF_DIGIT_H    = 140;
   localparam int unsigned DEF_DIGIT_GAP  = 20;
   localparam int unsigned DEF_BLINK_LOG2 = 4;

   localparam int unsigned CARD_MAX = 13;

   typedef enum logic {
      DIGIT_TENS = 1'b0,
      DIGIT_ONES = 1'b1
   } digit_sel_e;

   typedef struct packed {
      logic               lit;
      logic [VALUE_W-1:0] number;
   } glyph_t;

   // Card values above the deck range are stored as blank.
   function automatic logic [VALUE_W-1:0] card_sanitize(input logic [VALUE_W-1:0] v);
      return (v > VALUE_W'(CARD_MAX)) ? '0 : v;
   endfunction

   // Glyph shown at one digit position of a stored card value.
   function automatic glyph_t card_glyph(input logic [VALUE_W-1:0] card,
                                         input digit_sel_e         sel);
      glyph_t g;
      g.lit    = 1'b0;
      g.number = '0;
      if (card >= VALUE_W'(10)) begin
         g.lit    = 1'b1;
         g.number = (sel == DIGIT_TENS) ? VALUE_W'(1) : VALUE_W'(card - VALUE_W'(10));
      end else if ((card != '0) && (sel == DIGIT_ONES)) begin
         g.lit    = 1'b1;
         g.number = card;
      end
      return g;
   endfunction

endpackage

// File: rtl/card_digit_scheduler_slot_locate.sv
// Combinational raster decode: which slot box / digit glyph a pixel falls in.
module card_slot_locate
   import card_digit_scheduler_pkg::*;
#(
   parameter int unsigned GRID_X0   = DEF_GRID_X0,
   parameter int unsigned GRID_Y0   = DEF_GRID_Y0,
   parameter int unsigned COL_PITCH = DEF_COL_PITCH,
   parameter int unsigned ROW_PITCH = DEF_ROW_PITCH,
   parameter int unsigned DIGIT_W   = DEF_DIGIT_W,
   parameter int unsigned DIGIT_H   = DEF_DIGIT_H,
   parameter int unsigned DIGIT_GAP = DEF_DIGIT_GAP
) (
   input  logic [COORD_W-1:0] sx,
   input  logic [COORD_W-1:0] sy,
   output logic               in_box,
   output logic [SLOT_W-1:0]  slot,
   output digit_sel_e         digit_sel,
   output logic               in_glyph,
   output logic [COORD_W-1:0] x_off,
   output logic [COORD_W-1:0] y_off
);

   localparam int unsigned EXT_W = COORD_W + 1;
   localparam logic [EXT_W-1:0] COL0_X  = EXT_W'(GRID_X0);
   localparam logic [EXT_W-1:0] COL1_X  = EXT_W'(GRID_X0 + COL_PITCH);
   localparam logic [EXT_W-1:0] ROW0_Y  = EXT_W'(GRID_Y0);
   localparam logic [EXT_W-1:0] ROW1_Y  = EXT_W'(GRID_Y0 + ROW_PITCH);
   localparam logic [EXT_W-1:0] BOX_W   = EXT_W'(2 * DIGIT_W + DIGIT_GAP);
   localparam logic [EXT_W-1:0] BOX_H   = EXT_W'(DIGIT_H);
   localparam logic [EXT_W-1:0] GLYPH_W = EXT_W'(DIGIT_W);
   localparam logic [EXT_W-1:0] ONES_X  = EXT_W'(DIGIT_W + DIGIT_GAP);

   logic [EXT_W-1:0] sx_w;
   logic [EXT_W-1:0] sy_w;
   logic [EXT_W-1:0] box_x;
   logic [EXT_W-1:0] box_y;
   logic [EXT_W-1:0] dx;
   logic [EXT_W-1:0] dy;
   logic             col_hit;
   logic             row_hit;
   logic             col;
   logic             row;

   assign sx_w = {1'b0, sx};
   assign sy_w = {1'b0, sy};

   // Column and row membership with half-open bounds.
   always_comb begin
      col_hit = 1'b0;
      col     = 1'b0;
      box_x   = COL0_X;
      row_hit = 1'b0;
      row     = 1'b0;
      box_y   = ROW0_Y;
      if ((sx_w >= COL0_X) && (sx_w < COL0_X + BOX_W)) begin
         col_hit = 1'b1;
      end else if ((sx_w >= COL1_X) && (sx_w < COL1_X + BOX_W)) begin
         col_hit = 1'b1;
         col     = 1'b1;
         box_x   = COL1_X;
      end
      if ((sy_w >= ROW0_Y) && (sy_w < ROW0_Y + BOX_H)) begin
         row_hit = 1'b1;
      end else if ((sy_w >= ROW1_Y) && (sy_w < ROW1_Y + BOX_H)) begin
         row_hit = 1'b1;
         row     = 1'b1;
         box_y   = ROW1_Y;
      end
   end

   // Digit position inside the box; the gap between glyphs is not a glyph.
   always_comb begin
      in_box    = col_hit & row_hit;
      slot      = {row, col};
      dx        = sx_w - box_x;
      dy        = sy_w - box_y;
      digit_sel = DIGIT_TENS;
      in_glyph  = 1'b0;
      x_off     = '0;
      y_off     = '0;
      if (in_box) begin
         if (dx < GLYPH_W) begin
            in_glyph = 1'b1;
            x_off    = COORD_W'(dx);
            y_off    = COORD_W'(dy);
         end else if (dx >= ONES_X) begin
            digit_sel = DIGIT_ONES;
            in_glyph  = 1'b1;
            x_off     = COORD_W'(dx - ONES_X);
            y_off     = COORD_W'(dy);
         end
      end
   end

endmodule

// File: rtl/card_digit_scheduler.sv
// Time-shares one glyph renderer across the four card slots of the game screen.
module card_digit_scheduler
   import card_digit_scheduler_pkg::*;
#(
   parameter int unsigned GRID_X0    = DEF_GRID_X0,
   parameter int unsigned GRID_Y0    = DEF_GRID_Y0,
   parameter int unsigned COL_PITCH  = DEF_COL_PITCH,
   parameter int unsigned ROW_PITCH  = DEF_ROW_PITCH,
   parameter int unsigned DIGIT_W    = DEF_DIGIT_W,
   parameter int unsigned DIGIT_H    = DEF_DIGIT_H,
   parameter int unsigned DIGIT_GAP  = DEF_DIGIT_GAP,
   parameter int unsigned BLINK_LOG2 = DEF_BLINK_LOG2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [COORD_W-1:0] sx,
   input  logic [COORD_W-1:0] sy,
   input  logic               frame_start,
   input  logic               card_wr_valid,
   output logic               card_wr_ready,
   input  logic [SLOT_W-1:0]  card_wr_slot,
   input  logic [VALUE_W-1:0] card_wr_value,
   input  logic               sel_en,
   input  logic [SLOT_W-1:0]  sel_slot,
   output logic [COORD_W-1:0] glyph_sx_offset,
   output logic [COORD_W-1:0] glyph_sy_offset,
   output logic [VALUE_W-1:0] glyph_number,
   input  logic               glyph_hit,
   output logic               pix_on,
   output logic               pix_sel
);

   localparam int unsigned BLINK_W = BLINK_LOG2 + 1;

   logic                              loc_in_box;
   logic [SLOT_W-1:0]                 loc_slot;
   digit_sel_e                        loc_digit_sel;
   logic                              loc_in_glyph;
   logic [COORD_W-1:0]                loc_x_off;
   logic [COORD_W-1:0]                loc_y_off;

   logic [NUM_SLOTS-1:0][VALUE_W-1:0] cards_q,     cards_d;
   logic                              buf_valid_q, buf_valid_d;
   logic [SLOT_W-1:0]                 buf_slot_q,  buf_slot_d;
   logic [VALUE_W-1:0]                buf_value_q, buf_value_d;
   logic                              ready_q,     ready_d;
   logic [BLINK_W-1:0]                blink_q,     blink_d;

   logic [COORD_W-1:0]                s1_x_q,      s1_x_d;
   logic [COORD_W-1:0]                s1_y_q,      s1_y_d;
   logic [VALUE_W-1:0]                s1_num_q,    s1_num_d;
   logic                              s1_valid_q,  s1_valid_d;
   logic                              s1_hide_q,   s1_hide_d;
   logic                              s1_sel_q,    s1_sel_d;
   logic                              pix_on_q,    pix_on_d;
   logic                              pix_sel_q,   pix_sel_d;

   glyph_t                            cur_glyph;
   logic                              slot_is_sel;
   logic                              glyph_lit;

   card_slot_locate #(
      .GRID_X0   (GRID_X0),
      .GRID_Y0   (GRID_Y0),
      .COL_PITCH (COL_PITCH),
      .ROW_PITCH (ROW_PITCH),
      .DIGIT_W   (DIGIT_W),
      .DIGIT_H   (DIGIT_H),
      .DIGIT_GAP (DIGIT_GAP)
   ) u_locate (
      .sx        (sx),
      .sy        (sy),
      .in_box    (loc_in_box),
      .slot      (loc_slot),
      .digit_sel (loc_digit_sel),
      .in_glyph  (loc_in_glyph),
      .x_off     (loc_x_off),
      .y_off     (loc_y_off)
   );

   // Staging buffer, frame-synchronous commit and blink counter.
   always_comb begin
      cards_d     = cards_q;
      buf_valid_d = buf_valid_q;
      buf_slot_d  = buf_slot_q;
      buf_value_d = buf_value_q;
      blink_d     = blink_q;
      // A write taken on a frame_start cycle was not yet buffered, so it waits a frame.
      if (frame_start && buf_valid_q) begin
         cards_d[buf_slot_q] = card_sanitize(buf_value_q);
         buf_valid_d         = 1'b0;
      end
      if (card_wr_valid && ready_q) begin
         buf_valid_d = 1'b1;
         buf_slot_d  = card_wr_slot;
         buf_value_d = card_wr_value;
      end
      if (frame_start) begin
         blink_d = blink_q + BLINK_W'(1);
      end
      ready_d = ~buf_valid_d;
   end

   // Stage 1: pick the glyph for this pixel; stage 2: fold in renderer hit and blink.
   always_comb begin
      cur_glyph   = card_glyph(cards_q[loc_slot], loc_digit_sel);
      slot_is_sel = sel_en && (sel_slot == loc_slot);
      glyph_lit   = loc_in_glyph && cur_glyph.lit;
      s1_valid_d  = glyph_lit;
      s1_num_d    = glyph_lit ? cur_glyph.number : '0;
      s1_x_d      = glyph_lit ? loc_x_off : '0;
      s1_y_d      = glyph_lit ? loc_y_off : '0;
      s1_hide_d   = slot_is_sel && blink_q[BLINK_W-1];
      s1_sel_d    = loc_in_box && slot_is_sel;
      pix_on_d    = glyph_hit && s1_valid_q && !s1_hide_q;
      pix_sel_d   = s1_sel_q;
   end

   // State and pipeline registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cards_q     <= '0;
         buf_valid_q <= 1'b0;
         buf_slot_q  <= '0;
         buf_value_q <= '0;
         ready_q     <= 1'b1;
         blink_q     <= '0;
         s1_x_q      <= '0;
         s1_y_q      <= '0;
         s1_num_q    <= '0;
         s1_valid_q  <= 1'b0;
         s1_hide_q   <= 1'b0;
         s1_sel_q    <= 1'b0;
         pix_on_q    <= 1'b0;
         pix_sel_q   <= 1'b0;
      end else begin
         cards_q     <= cards_d;
         buf_valid_q <= buf_valid_d;
         buf_slot_q  <= buf_slot_d;
         buf_value_q <= buf_value_d;
         ready_q     <= ready_d;
         blink_q     <= blink_d;
         s1_x_q      <= s1_x_d;
         s1_y_q      <= s1_y_d;
         s1_num_q    <= s1_num_d;
         s1_valid_q  <= s1_valid_d;
         s1_hide_q   <= s1_hide_d;
         s1_sel_q    <= s1_sel_d;
         pix_on_q    <= pix_on_d;
         pix_sel_q   <= pix_sel_d;
      end
   end

   assign card_wr_ready   = ready_q;
   assign glyph_sx_offset = s1_x_q;
   assign glyph_sy_offset = s1_y_q;
   assign glyph_number    = s1_num_q;
   assign pix_on          = pix_on_q;
   assign pix_sel         = pix_sel_q;

endmodule

// File: tb/tb_card_digit_scheduler.sv
// Directed + random pixel bench for card_digit_scheduler against a screen-level model.
module tb_card_digit_scheduler;

   localparam int GX0 = 80;
   localparam int GY0 = 60;
   localparam int CP  = 300;
   localparam int RP  = 200;
   localparam int DW  = 80;
   localparam int DH  = 140;
   localparam int DG  = 20;
   localparam int BW  = 2 * DW + DG;

   logic       clk;
   logic       rst_n;
   logic [9:0] sx;
   logic [9:0] sy;
   logic       frame_start;
   logic       card_wr_valid;
   logic       card_wr_ready;
   logic [1:0] card_wr_slot;
   logic [3:0] card_wr_value;
   logic       sel_en;
   logic [1:0] sel_slot;
   logic [9:0] glyph_sx_offset;
   logic [9:0] glyph_sy_offset;
   logic [3:0] glyph_number;
   logic       glyph_hit;
   logic       pix_on;
   logic       pix_sel;

   int tests = 0;
   int fails = 0;

   // Screen-level model state
   int m_cards [4];
   bit m_buf_valid;
   int m_buf_slot;
   int m_buf_val;
   int m_frames;
   // Expected stage-1 contents after the most recent edge
   int p_vld, p_num, p_xo, p_yo;
   bit p_hide, p_bsel;

   // Stand-in renderer: arbitrary but deterministic pattern over offsets and digit.
   function automatic bit rend(input int x, input int y, input int n);
      return ((3 * x + 5 * y + 7 * n) % 4) != 0;
   endfunction

   assign glyph_hit = rend(int'(glyph_sx_offset), int'(glyph_sy_offset), int'(glyph_number));

   card_digit_scheduler dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .sx              (sx),
      .sy              (sy),
      .frame_start     (frame_start),
      .card_wr_valid   (card_wr_valid),
      .card_wr_ready   (card_wr_ready),
      .card_wr_slot    (card_wr_slot),
      .card_wr_value   (card_wr_value),
      .sel_en          (sel_en),
      .sel_slot        (sel_slot),
      .glyph_sx_offset (glyph_sx_offset),
      .glyph_sy_offset (glyph_sy_offset),
      .glyph_number    (glyph_number),
      .glyph_hit       (glyph_hit),
      .pix_on          (pix_on),
      .pix_sel         (pix_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // What the screen shows at (x,y) given the current cards.
   function automatic void model_pix(input int x, input int y,
                                     output int vld, output int num, output int xo,
                                     output int yo, output int slot, output int inbox);
      int ox, oy, v, tens, ones;
      vld = 0; num = 0; xo = 0; yo = 0; slot = 0; inbox = 0;
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 2; c++) begin
            ox = GX0 + c * CP;
            oy = GY0 + r * RP;
            if (x >= ox && x < ox + BW && y >= oy && y < oy + DH) begin
               inbox = 1;
               slot  = r * 2 + c;
               v     = m_cards[slot];
               tens  = (v >= 10) ? 1 : -1;
               ones  = (v >= 10) ? v - 10 : ((v == 0) ? -1 : v);
               if (x - ox < DW && tens >= 0) begin
                  vld = 1; num = tens; xo = x - ox; yo = y - oy;
               end else if (x - ox >= DW + DG && ones >= 0) begin
                  vld = 1; num = ones; xo = x - ox - DW - DG; yo = y - oy;
               end
            end
         end
      end
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_cards[i] = 0;
      m_buf_valid = 0; m_buf_slot = 0; m_buf_val = 0; m_frames = 0;
   endtask

   // One clock: drive a pixel, advance, then check every output against the model.
   task automatic tick(input int x, input int y, input bit fs);
      int vld, num, xo, yo, slot, inbox;
      bit e_on, e_sel, hide, bsel, acc;
      int a_slot, a_val;
      sx          = 10'(x);
      sy          = 10'(y);
      frame_start = fs;
      e_on  = (p_vld != 0) && !p_hide && rend(p_xo, p_yo, p_num);
      e_sel = p_bsel;
      model_pix(x, y, vld, num, xo, yo, slot, inbox);
      hide   = sel_en && (int'(sel_slot) == slot) && ((m_frames % 32) >= 16);
      bsel   = (inbox != 0) && sel_en && (int'(sel_slot) == slot);
      acc    = card_wr_valid && !m_buf_valid;
      a_slot = int'(card_wr_slot);
      a_val  = int'(card_wr_value);
      @(posedge clk);
      #1;
      if (!rst_n) begin
         model_reset();
         p_vld = 0; p_num = 0; p_xo = 0; p_yo = 0; p_hide = 0; p_bsel = 0;
         e_on = 0; e_sel = 0;
      end else begin
         if (fs && m_buf_valid) begin
            m_cards[m_buf_slot] = (m_buf_val > 13) ? 0 : m_buf_val;
            m_buf_valid = 0;
         end
         if (acc) begin
            m_buf_valid = 1; m_buf_slot = a_slot; m_buf_val = a_val;
            card_wr_valid = 1'b0;
         end
         if (fs) m_frames = (m_frames + 1) % 32;
         p_vld = vld; p_num = num; p_xo = xo; p_yo = yo; p_hide = hide; p_bsel = bsel;
      end
      chk("glyph_number", int'(glyph_number), p_num);
      chk("glyph_sx_offset", int'(glyph_sx_offset), p_xo);
      chk("glyph_sy_offset", int'(glyph_sy_offset), p_yo);
      chk("card_wr_ready", int'(card_wr_ready), m_buf_valid ? 0 : 1);
      chk("pix_on", int'(pix_on), int'(e_on));
      chk("pix_sel", int'(pix_sel), int'(e_sel));
   endtask

   task automatic frame();
      tick(0, 0, 1'b1);
   endtask

   task automatic scan(input int n);
      for (int i = 0; i < n; i++) tick(60 + $urandom_range(0, 540), 40 + $urandom_range(0, 380), 1'b0);
   endtask

   task automatic scan_box(input int s, input int n);
      int ox, oy;
      ox = GX0 + (s % 2) * CP;
      oy = GY0 + (s / 2) * RP;
      for (int i = 0; i < n; i++) tick(ox + $urandom_range(0, BW - 1), oy + $urandom_range(0, DH - 1), 1'b0);
   endtask

   // Present a write and wait (bounded) until the model says it was taken.
   task automatic write_card(input int s, input int v);
      card_wr_slot  = 2'(s);
      card_wr_value = 4'(v);
      card_wr_valid = 1'b1;
      for (int i = 0; i < 8 && card_wr_valid; i++) tick(0, 0, 1'b0);
      if (card_wr_valid) begin
         chk("wr_accept_timeout", 0, 1);
         card_wr_valid = 1'b0;
      end
   endtask

   initial begin
      rst_n = 1'b0; sx = '0; sy = '0; frame_start = 1'b0;
      card_wr_valid = 1'b0; card_wr_slot = '0; card_wr_value = '0;
      sel_en = 1'b0; sel_slot = '0;
      model_reset();
      p_vld = 0; p_num = 0; p_xo = 0; p_yo = 0; p_hide = 0; p_bsel = 0;

      // Reset held for 3 clocks
      for (int i = 0; i < 3; i++) tick(GX0 + 5, GY0 + 5, 1'b0);
      chk("rst_pix_on", int'(pix_on), 0);
      chk("rst_ready", int'(card_wr_ready), 1);
      rst_n = 1'b1;
      scan(20);

      // slot0 = 7 on ones glyph
      write_card(0, 7);
      chk("t2_ready_low", int'(card_wr_ready), 0);
      frame();
      tick(GX0 + DW + DG + 10, GY0 + 5, 1'b0);
      chk("t2_number", int'(glyph_number), 7);
      chk("t2_xoff", int'(glyph_sx_offset), 10);
      chk("t2_yoff", int'(glyph_sy_offset), 5);
      tick(0, 0, 1'b0);
      scan_box(0, 40);

      // slot3 = 12: tens then ones
      write_card(3, 12);
      frame();
      tick(GX0 + CP + 5, GY0 + RP + 5, 1'b0);
      chk("t3_tens", int'(glyph_number), 1);
      chk("t3_tens_xoff", int'(glyph_sx_offset), 5);
      chk("t3_tens_yoff", int'(glyph_sy_offset), 5);
      tick(GX0 + CP + DW + DG + 5, GY0 + RP + 5, 1'b0);
      chk("t3_ones", int'(glyph_number), 2);
      chk("t3_ones_xoff", int'(glyph_sx_offset), 5);
      // box edges: last glyph column, gap, one past the box
      tick(GX0 + CP + DW - 1, GY0 + RP + DH - 1, 1'b0);
      tick(GX0 + CP + DW, GY0 + RP, 1'b0);
      tick(GX0 + CP + BW, GY0 + RP, 1'b0);
      tick(GX0 + CP + BW - 1, GY0 + RP + DH, 1'b0);
      scan_box(3, 40);

      // slot1 = 5 written on a frame_start cycle
      card_wr_slot = 2'd1; card_wr_value = 4'd5; card_wr_valid = 1'b1;
      frame();
      chk("t4_taken", int'(card_wr_valid), 0);
      scan_box(1, 30);
      card_wr_slot = 2'd0; card_wr_value = 4'd3; card_wr_valid = 1'b1;
      for (int i = 0; i < 5; i++) tick(GX0 + CP + DW + DG + 3, GY0 + 7, 1'b0);
      chk("t4_stalled", int'(card_wr_valid), 1);
      frame();
      tick(GX0 + CP + DW + DG + 3, GY0 + 7, 1'b0);
      chk("t4_visible", int'(glyph_number), 5);
      for (int i = 0; i < 4 && card_wr_valid; i++) tick(0, 0, 1'b0);
      chk("t4_second_taken", int'(card_wr_valid), 0);
      frame();
      scan(60);

      // Blink on slot2 = 9
      sel_en = 1'b1; sel_slot = 2'd2;
      write_card(2, 9);
      for (int f = 0; f < 40; f++) begin
         frame();
         tick(GX0 + DW + DG + 1, GY0 + RP + 5, 1'b0);
         tick(GX0 + 3, GY0 + RP + 3, 1'b0);
         tick(0, 0, 1'b0);
         chk("t5_pix_sel_box", int'(pix_sel), 1);
      end
      scan(60);
      sel_en = 1'b0;

      // Value 15 commits as blank, then mid-frame reset
      write_card(3, 15);
      frame();
      scan_box(3, 40);
      write_card(0, 4);
      scan(5);
      rst_n = 1'b0;
      tick(GX0 + 10, GY0 + 10, 1'b0);
      rst_n = 1'b1;
      chk("t6_ready_after_rst", int'(card_wr_ready), 1);
      frame();
      for (int s = 0; s < 4; s++) scan_box(s, 25);
      scan(40);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
